// File: rtl/uart_rx_cmd_decoder.sv
// Decodes UART RX byte frames into register-file write/read and ALU start strobes.
// Optional inter-byte frame timeout is enabled with macro UART_RX_CMD_TIMEOUT_EN.
module uart_rx_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_p_data,
    input  logic       rx_d_vld,
    output logic       wr_en,
    output logic       rd_en,
    output logic [3:0] addr,
    output logic [7:0] wr_data,
    output logic       alu_en,
    output logic [3:0] alu_fun,
    output logic       busy,
    output logic       cmd_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        ALU_A,
        ALU_B,
        ALU_FUN
    } state_t;

    state_t     state, state_next;
    logic       wr_en_next, rd_en_next, alu_en_next, cmd_err_next;
    logic [3:0] addr_next, alu_fun_next;
    logic [7:0] wr_data_next;
    logic       timeout;

`ifdef UART_RX_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (rx_d_vld || state == IDLE) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    // A byte in the expiry cycle wins over the timeout.
    always_comb begin
        timeout = (state != IDLE) && !rx_d_vld &&
                  (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
`else
    always_comb begin
        timeout = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        wr_en_next   = 1'b0;
        rd_en_next   = 1'b0;
        alu_en_next  = 1'b0;
        cmd_err_next = 1'b0;
        addr_next    = addr;
        wr_data_next = wr_data;
        alu_fun_next = alu_fun;

        if (rx_d_vld) begin
            case (state)
                IDLE: begin
                    case (rx_p_data)
                        8'hAA:   state_next = WR_ADDR;
                        8'hBB:   state_next = RD_ADDR;
                        8'hCC:   state_next = ALU_A;
                        8'hDD:   state_next = ALU_FUN;
                        default: cmd_err_next = 1'b1;
                    endcase
                end
                WR_ADDR: begin
                    addr_next  = rx_p_data[3:0];
                    state_next = WR_DATA;
                end
                WR_DATA: begin
                    wr_data_next = rx_p_data;
                    wr_en_next   = 1'b1;
                    state_next   = IDLE;
                end
                RD_ADDR: begin
                    addr_next  = rx_p_data[3:0];
                    rd_en_next = 1'b1;
                    state_next = IDLE;
                end
                ALU_A: begin
                    addr_next    = 4'h0;
                    wr_data_next = rx_p_data;
                    wr_en_next   = 1'b1;
                    state_next   = ALU_B;
                end
                ALU_B: begin
                    addr_next    = 4'h1;
                    wr_data_next = rx_p_data;
                    wr_en_next   = 1'b1;
                    state_next   = ALU_FUN;
                end
                ALU_FUN: begin
                    alu_fun_next = rx_p_data[3:0];
                    alu_en_next  = 1'b1;
                    state_next   = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout) begin
            state_next   = IDLE;
            cmd_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            alu_en  <= 1'b0;
            cmd_err <= 1'b0;
            busy    <= 1'b0;
            addr    <= '0;
            wr_data <= '0;
            alu_fun <= '0;
        end else begin
            wr_en   <= wr_en_next;
            rd_en   <= rd_en_next;
            alu_en  <= alu_en_next;
            cmd_err <= cmd_err_next;
            busy    <= (state_next != IDLE);
            addr    <= addr_next;
            wr_data <= wr_data_next;
            alu_fun <= alu_fun_next;
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Self-checking bench for uart_rx_cmd_decoder: vector table plus reset and
// frame-timeout sequences (timeout path exercised when UART_RX_CMD_TIMEOUT_EN is defined).
module tb_uart_rx_cmd_decoder;

    typedef struct packed {
        logic       wr_en;
        logic       rd_en;
        logic       alu_en;
        logic       cmd_err;
        logic       busy;
        logic [3:0] addr;
        logic [7:0] wr_data;
        logic [3:0] alu_fun;
    } out_t;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_p_data = '0;
    logic       rx_d_vld = 1'b0;
    logic       wr_en, rd_en, alu_en, cmd_err, busy;
    logic [3:0] addr, alu_fun;
    logic [7:0] wr_data;

    int unsigned checks = 0;
    int unsigned failures = 0;
    out_t        sb_q[$];
    vec_t        vecs[27];

    uart_rx_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_p_data (rx_p_data),
        .rx_d_vld  (rx_d_vld),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .alu_en    (alu_en),
        .alu_fun   (alu_fun),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic we, input logic re, input logic ae,
                                input logic ce, input logic b, input logic [3:0] a,
                                input logic [7:0] wd, input logic [3:0] af);
        out_t o;
        o.wr_en = we; o.rd_en = re; o.alu_en = ae; o.cmd_err = ce; o.busy = b;
        o.addr = a; o.wr_data = wd; o.alu_fun = af;
        return o;
    endfunction

    function automatic out_t sample();
        return mk(wr_en, rd_en, alu_en, cmd_err, busy, addr, wr_data, alu_fun);
    endfunction

    task automatic compare(input string name, input out_t exp);
        out_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got we=%b re=%b ae=%b err=%b busy=%b addr=%h wd=%h af=%h, expected we=%b re=%b ae=%b err=%b busy=%b addr=%h wd=%h af=%h",
                     name, act.wr_en, act.rd_en, act.alu_en, act.cmd_err, act.busy,
                     act.addr, act.wr_data, act.alu_fun, exp.wr_en, exp.rd_en,
                     exp.alu_en, exp.cmd_err, exp.busy, exp.addr, exp.wr_data, exp.alu_fun);
        end
    endtask

    // Drive one cycle of input; outputs for that byte are due one edge later.
    task automatic step(input string name, input logic vld, input logic [7:0] d, input out_t exp);
        out_t e;
        rx_d_vld  = vld;
        rx_p_data = d;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        rx_d_vld = 1'b0;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            compare(name, e);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h00, mk(0,0,0,0,0,4'h0,8'h00,4'h0)};
        vecs[1]  = '{1'b1, 8'hAA, mk(0,0,0,0,1,4'h0,8'h00,4'h0)};
        vecs[2]  = '{1'b1, 8'h05, mk(0,0,0,0,1,4'h5,8'h00,4'h0)};
        vecs[3]  = '{1'b1, 8'h3C, mk(1,0,0,0,0,4'h5,8'h3C,4'h0)};
        vecs[4]  = '{1'b0, 8'h00, mk(0,0,0,0,0,4'h5,8'h3C,4'h0)};
        vecs[5]  = '{1'b1, 8'hBB, mk(0,0,0,0,1,4'h5,8'h3C,4'h0)};
        vecs[6]  = '{1'b1, 8'h1F, mk(0,1,0,0,0,4'hF,8'h3C,4'h0)};
        vecs[7]  = '{1'b0, 8'h00, mk(0,0,0,0,0,4'hF,8'h3C,4'h0)};
        vecs[8]  = '{1'b1, 8'hCC, mk(0,0,0,0,1,4'hF,8'h3C,4'h0)};
        vecs[9]  = '{1'b1, 8'h12, mk(1,0,0,0,1,4'h0,8'h12,4'h0)};
        vecs[10] = '{1'b1, 8'h34, mk(1,0,0,0,1,4'h1,8'h34,4'h0)};
        vecs[11] = '{1'b1, 8'h02, mk(0,0,1,0,0,4'h1,8'h34,4'h2)};
        vecs[12] = '{1'b1, 8'h55, mk(0,0,0,1,0,4'h1,8'h34,4'h2)};
        vecs[13] = '{1'b0, 8'h00, mk(0,0,0,0,0,4'h1,8'h34,4'h2)};
        vecs[14] = '{1'b1, 8'hDD, mk(0,0,0,0,1,4'h1,8'h34,4'h2)};
        vecs[15] = '{1'b1, 8'h07, mk(0,0,1,0,0,4'h1,8'h34,4'h7)};
        vecs[16] = '{1'b0, 8'hAA, mk(0,0,0,0,0,4'h1,8'h34,4'h7)};
        vecs[17] = '{1'b1, 8'hAA, mk(0,0,0,0,1,4'h1,8'h34,4'h7)};
        vecs[18] = '{1'b0, 8'h99, mk(0,0,0,0,1,4'h1,8'h34,4'h7)};
        vecs[19] = '{1'b1, 8'h0A, mk(0,0,0,0,1,4'hA,8'h34,4'h7)};
        vecs[20] = '{1'b1, 8'hFF, mk(1,0,0,0,0,4'hA,8'hFF,4'h7)};
        vecs[21] = '{1'b1, 8'h00, mk(0,0,0,1,0,4'hA,8'hFF,4'h7)};
        vecs[22] = '{1'b1, 8'hCC, mk(0,0,0,0,1,4'hA,8'hFF,4'h7)};
        vecs[23] = '{1'b1, 8'h00, mk(1,0,0,0,1,4'h0,8'h00,4'h7)};
        vecs[24] = '{1'b1, 8'hFF, mk(1,0,0,0,1,4'h1,8'hFF,4'h7)};
        vecs[25] = '{1'b1, 8'h1F, mk(0,0,1,0,0,4'h1,8'hFF,4'hF)};
        vecs[26] = '{1'b0, 8'h00, mk(0,0,0,0,0,4'h1,8'hFF,4'hF)};

        repeat (2) @(posedge clk);
        #1;
        compare("reset_state", mk(0,0,0,0,0,4'h0,8'h00,4'h0));
        rst = 1'b1;

        for (int i = 0; i < 27; i++) begin
            step($sformatf("vec%0d", i), vecs[i].vld, vecs[i].data, vecs[i].exp);
        end

        // Reset in the middle of a write frame discards it.
        step("rst_aa", 1'b1, 8'hAA, mk(0,0,0,0,1,4'h1,8'hFF,4'hF));
        step("rst_03", 1'b1, 8'h03, mk(0,0,0,0,1,4'h3,8'hFF,4'hF));
        rst = 1'b0;
        #1;
        compare("rst_async", mk(0,0,0,0,0,4'h0,8'h00,4'h0));
        @(posedge clk);
        #1;
        compare("rst_held", mk(0,0,0,0,0,4'h0,8'h00,4'h0));
        rst = 1'b1;
        step("rst_after", 1'b0, 8'h00, mk(0,0,0,0,0,4'h0,8'h00,4'h0));
        step("rst_99", 1'b1, 8'h99, mk(0,0,0,1,0,4'h0,8'h00,4'h0));
        step("rst_idle", 1'b0, 8'h00, mk(0,0,0,0,0,4'h0,8'h00,4'h0));

`ifdef UART_RX_CMD_TIMEOUT_EN
        step("to_aa", 1'b1, 8'hAA, mk(0,0,0,0,1,4'h0,8'h00,4'h0));
        for (int i = 0; i < 15; i++) begin
            step($sformatf("to_wait%0d", i), 1'b0, 8'h00, mk(0,0,0,0,1,4'h0,8'h00,4'h0));
        end
        step("to_expire", 1'b0, 8'h00, mk(0,0,0,1,0,4'h0,8'h00,4'h0));
        step("to_idle", 1'b0, 8'h00, mk(0,0,0,0,0,4'h0,8'h00,4'h0));
        step("to_bb", 1'b1, 8'hBB, mk(0,0,0,0,1,4'h0,8'h00,4'h0));
        step("to_02", 1'b1, 8'h02, mk(0,1,0,0,0,4'h2,8'h00,4'h0));
        step("late_aa", 1'b1, 8'hAA, mk(0,0,0,0,1,4'h2,8'h00,4'h0));
        for (int i = 0; i < 15; i++) begin
            step($sformatf("late_wait%0d", i), 1'b0, 8'h00, mk(0,0,0,0,1,4'h2,8'h00,4'h0));
        end
        step("late_04", 1'b1, 8'h04, mk(0,0,0,0,1,4'h4,8'h00,4'h0));
        step("late_77", 1'b1, 8'h77, mk(1,0,0,0,0,4'h4,8'h77,4'h0));
`else
        step("wait_aa", 1'b1, 8'hAA, mk(0,0,0,0,1,4'h0,8'h00,4'h0));
        for (int i = 0; i < 40; i++) begin
            step($sformatf("wait%0d", i), 1'b0, 8'h00, mk(0,0,0,0,1,4'h0,8'h00,4'h0));
        end
        step("wait_04", 1'b1, 8'h04, mk(0,0,0,0,1,4'h4,8'h00,4'h0));
        step("wait_77", 1'b1, 8'h77, mk(1,0,0,0,0,4'h4,8'h77,4'h0));
`endif
        step("final_idle", 1'b0, 8'h00, mk(0,0,0,0,0,4'h4,8'h77,4'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Strobes must never overlap.
    always @(negedge clk) begin
        if (rst && (int'(wr_en) + int'(rd_en) + int'(alu_en) + int'(cmd_err) > 1)) begin
            checks++;
            failures++;
            $display("FAIL strobe_overlap: got we=%b re=%b ae=%b err=%b, expected at most one high",
                     wr_en, rd_en, alu_en, cmd_err);
        end
    end

endmodule
